// File: rtl/conv_result_streamer.sv
// conv_result_streamer: captures one OUT_SIZE x OUT_SIZE result map from the
// ReLU write stream, then drains it in raster order over a valid/ready link
// with row-end and frame-last markers. Re-armed by i_clear.
module conv_result_streamer #(
  parameter int OUT_SIZE   = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_en,
  input  logic signed [DATA_WIDTH-1:0] i_data,
  input  logic                         i_clear,
  input  logic                         i_ready,
  output logic                         o_valid,
  output logic signed [DATA_WIDTH-1:0] o_data,
  output logic                         o_row_end,
  output logic                         o_last,
  output logic                         o_done,
  output logic                         o_overflow
);

  localparam int DEPTH  = OUT_SIZE * OUT_SIZE;
  localparam int CNT_W  = $clog2(DEPTH) + 1;
  // Address width is kept exactly matched to the storage so indexing is clean;
  // storage is rounded up to a power of two, only the first DEPTH entries used.
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int MEM_D  = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

  typedef enum logic [1:0] {FILL, PREFETCH, DRAIN, DONE} state_t;

  state_t                        state_reg, state_next;
  logic [CNT_W-1:0]              wr_ptr_reg, wr_ptr_next;
  logic [CNT_W-1:0]              rd_ptr_reg, rd_ptr_next;
  logic                          valid_reg, valid_next;
  logic                          row_end_reg, row_end_next;
  logic                          last_reg, last_next;
  logic                          done_reg, done_next;
  logic                          ovf_reg, ovf_next;
  logic signed [DATA_WIDTH-1:0]  data_reg;
  logic signed [DATA_WIDTH-1:0]  mem [0:MEM_D-1];
  logic [MEM_D-1:0]              row_end_mask;
  logic                          wr_en;
  logic                          rd_en;
  logic [ADDR_W-1:0]             rd_addr;
  logic                          handshake;

  assign handshake = valid_reg & i_ready;

  // Constant per-address "last column" table, avoids a runtime modulo.
  generate
    for (genvar gi = 0; gi < MEM_D; gi++) begin : g_row_end
      assign row_end_mask[gi] = ((gi % OUT_SIZE) == (OUT_SIZE - 1));
    end
  endgenerate

  // Next-state, pointer and marker logic; i_clear overrides everything but reset.
  always_comb begin
    state_next   = state_reg;
    wr_ptr_next  = wr_ptr_reg;
    rd_ptr_next  = rd_ptr_reg;
    valid_next   = valid_reg;
    row_end_next = row_end_reg;
    last_next    = last_reg;
    done_next    = done_reg;
    ovf_next     = ovf_reg;
    wr_en        = 1'b0;
    rd_en        = 1'b0;
    rd_addr      = '0;
    if (i_clear) begin
      state_next   = FILL;
      wr_ptr_next  = '0;
      rd_ptr_next  = '0;
      valid_next   = 1'b0;
      row_end_next = 1'b0;
      last_next    = 1'b0;
      done_next    = 1'b0;
      ovf_next     = 1'b0;
    end else begin
      case (state_reg)
        FILL: begin
          if (i_en) begin
            wr_en       = 1'b1;
            wr_ptr_next = wr_ptr_reg + 1'b1;
            if (wr_ptr_reg == LAST_IDX) state_next = PREFETCH;
          end
        end
        PREFETCH: begin
          // Load the first sample so DRAIN starts with valid data.
          rd_en        = 1'b1;
          rd_addr      = '0;
          rd_ptr_next  = '0;
          valid_next   = 1'b1;
          row_end_next = row_end_mask[0];
          last_next    = (LAST_IDX == '0);
          state_next   = DRAIN;
        end
        DRAIN: begin
          if (handshake) begin
            if (last_reg) begin
              state_next   = DONE;
              valid_next   = 1'b0;
              row_end_next = 1'b0;
              last_next    = 1'b0;
              done_next    = 1'b1;
            end else begin
              // Read at the advanced pointer so back-to-back accepts have no bubble.
              rd_en        = 1'b1;
              rd_addr      = rd_ptr_reg[ADDR_W-1:0] + ADDR_W'(1);
              rd_ptr_next  = rd_ptr_reg + 1'b1;
              row_end_next = row_end_mask[rd_addr];
              last_next    = (rd_ptr_next == LAST_IDX);
            end
          end
        end
        DONE: begin
          state_next = DONE;
        end
        default: state_next = FILL;
      endcase
      // Writes arriving when the buffer is not accepting are lost and flagged.
      if (i_en && (state_reg != FILL)) ovf_next = 1'b1;
    end
  end

  // Control state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg   <= FILL;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      valid_reg   <= 1'b0;
      row_end_reg <= 1'b0;
      last_reg    <= 1'b0;
      done_reg    <= 1'b0;
      ovf_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      wr_ptr_reg  <= wr_ptr_next;
      rd_ptr_reg  <= rd_ptr_next;
      valid_reg   <= valid_next;
      row_end_reg <= row_end_next;
      last_reg    <= last_next;
      done_reg    <= done_next;
      ovf_reg     <= ovf_next;
    end
  end

  // Buffer write port; contents are not reset.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_ptr_reg[ADDR_W-1:0]] <= i_data;
  end

  // Registered read port; holds while the consumer stalls.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      data_reg <= '0;
    end else if (rd_en) begin
      data_reg <= mem[rd_addr];
    end
  end

  assign o_valid    = valid_reg;
  assign o_data     = data_reg;
  assign o_row_end  = row_end_reg;
  assign o_last     = last_reg;
  assign o_done     = done_reg;
  assign o_overflow = ovf_reg;

endmodule

// File: tb/tb_conv_result_streamer.sv
// Self-checking bench for conv_result_streamer: a table-driven first frame,
// hand-written corner sequences, and randomized frames against a queue model.
module tb_conv_result_streamer;
  localparam int N     = 4;
  localparam int DW    = 16;
  localparam int DEPTH = N * N;

  logic          clk = 1'b0;
  logic          rst, en, clear, ready;
  logic [DW-1:0] din, dout;
  logic          valid, row_end, last, done, ovf;

  int tests = 0;
  int fails = 0;
  logic [DW-1:0] exp_q[$];

  typedef struct {
    logic          en;
    logic [DW-1:0] data;
    logic          ready;
    logic          exp_valid;
    logic [DW-1:0] exp_data;
    logic          exp_row_end;
    logic          exp_last;
    logic          exp_done;
  } vec_t;
  vec_t tbl[34];

  conv_result_streamer #(.OUT_SIZE(N), .DATA_WIDTH(DW)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_data(din), .i_clear(clear),
    .i_ready(ready), .o_valid(valid), .o_data(dout), .o_row_end(row_end),
    .o_last(last), .o_done(done), .o_overflow(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change at negedge; outputs seen after tick reflect the edge just taken.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    exp_q.delete();
  endtask

  // Writes DEPTH samples with random gaps; records them in the model queue.
  task automatic fill(input int base, input int gap_pct, input bit rnd_data);
    for (int k = 0; k < DEPTH; k++) begin
      while ($urandom_range(0, 99) < gap_pct) begin
        en = 1'b0;
        tick();
      end
      en  = 1'b1;
      din = rnd_data ? DW'($urandom) : DW'(base + k);
      exp_q.push_back(din);
      tick();
    end
    en = 1'b0;
    $display("[TB] fill done base=%0d gaps=%0d%%", base, gap_pct);
  endtask

  // Drains n_hs samples under a ready pattern, comparing against the queue.
  // mode 0: always ready, 1: 1,0,0,1 pattern, 2: random. inj_at >= 0 injects
  // one stray write of 99 at that handshake count.
  task automatic drain(input int mode, input int n_hs, input int inj_at);
    int k = 0;
    int cyc = 0;
    int pos;
    bit stalled = 1'b0;
    bit injected = 1'b0;
    bit r;
    logic [3:0] pat = 4'b1001;
    logic [DW-1:0] sd;
    logic sr, sl;
    while (k < n_hs && cyc < 300) begin
      check("done_low_during_drain", done, 1'b0);
      if (stalled && valid) begin
        check("stall_data", dout, sd);
        check("stall_row_end", row_end, sr);
        check("stall_last", last, sl);
      end
      case (mode)
        0: r = 1'b1;
        1: r = pat[cyc % 4];
        default: r = 1'($urandom_range(0, 1));
      endcase
      ready = r;
      if (k == inj_at && !injected) begin
        en = 1'b1;
        din = DW'(99);
        injected = 1'b1;
      end else begin
        en = 1'b0;
      end
      if (valid && r) begin
        pos = DEPTH - exp_q.size();
        check("drain_data", dout, exp_q[0]);
        check("drain_row_end", row_end, (pos % N) == N - 1);
        check("drain_last", last, pos == DEPTH - 1);
        $display("[TB] handshake %0d data=%0h row_end=%0b last=%0b", pos, dout, row_end, last);
        exp_q.pop_front();
        k++;
        stalled = 1'b0;
      end else if (valid) begin
        stalled = 1'b1;
        sd = dout;
        sr = row_end;
        sl = last;
      end
      tick();
      cyc++;
    end
    en = 1'b0;
    ready = 1'b0;
    check("drain_cycle_budget", cyc >= 300, 1'b0);
    if (n_hs == DEPTH) begin
      check("done_after_last", done, 1'b1);
      check("valid_after_last", valid, 1'b0);
    end
  endtask

  initial begin
    for (int r = 0; r < 34; r++) begin
      tbl[r].en          = (r < 16);
      tbl[r].data        = (r < 16) ? DW'(r + 1) : '0;
      tbl[r].ready       = 1'b1;
      tbl[r].exp_valid   = (r >= 16) && (r <= 31);
      tbl[r].exp_data    = DW'(r - 15);
      tbl[r].exp_row_end = ((r - 16) % 4) == 3;
      tbl[r].exp_last    = (r == 31);
      tbl[r].exp_done    = (r >= 32);
    end

    rst = 1'b1; en = 1'b0; din = '0; clear = 1'b0; ready = 1'b0;
    @(negedge clk);
    tick();
    tick();
    check("rst_valid", valid, 0);
    check("rst_data", dout, 0);
    check("rst_row_end", row_end, 0);
    check("rst_last", last, 0);
    check("rst_done", done, 0);
    check("rst_ovf", ovf, 0);
    rst = 1'b0;
    $display("[TB] reset checked");

    // Scenario 1: table-driven fill 1..16 and full-rate drain, cycle by cycle.
    for (int r = 0; r < 34; r++) begin
      en = tbl[r].en;
      din = tbl[r].data;
      ready = tbl[r].ready;
      tick();
      check("t1_valid", valid, tbl[r].exp_valid);
      if (tbl[r].exp_valid) begin
        check("t1_data", dout, tbl[r].exp_data);
        check("t1_row_end", row_end, tbl[r].exp_row_end);
        check("t1_last", last, tbl[r].exp_last);
      end
      check("t1_done", done, tbl[r].exp_done);
      check("t1_ovf", ovf, 0);
      $display("[TB] vec %0d en=%0b valid=%0b data=%0h done=%0b", r, tbl[r].en, valid, dout, done);
    end
    en = 1'b0;
    do_clear();
    check("clear_done", done, 0);

    // Scenario 2: stalling consumer.
    fill(1, 0, 1'b0);
    drain(1, DEPTH, -1);
    do_clear();

    // Scenario 3: gapped writes.
    fill(1, 40, 1'b0);
    drain(0, DEPTH, -1);
    do_clear();

    // Scenario 4: stray write during drain sets sticky overflow.
    fill(1, 0, 1'b0);
    drain(0, DEPTH, 3);
    check("ovf_set", ovf, 1);
    tick();
    check("ovf_sticky", ovf, 1);
    do_clear();
    check("ovf_cleared", ovf, 0);
    check("clear_valid", valid, 0);

    // Scenario 5: abort after 7 writes; clear with a simultaneous write.
    for (int k = 0; k < 7; k++) begin
      en = 1'b1;
      din = DW'(k + 1);
      tick();
    end
    en = 1'b1;
    din = DW'(16'hDEAD);
    do_clear();
    en = 1'b0;
    check("clear_en_no_ovf", ovf, 0);
    check("clear_en_valid", valid, 0);
    fill(101, 0, 1'b0);
    drain(2, DEPTH, -1);
    do_clear();

    // Scenario 6: reset mid-drain after 5 handshakes.
    fill(1, 0, 1'b0);
    drain(0, 5, -1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_valid", valid, 0);
    check("mid_rst_data", dout, 0);
    check("mid_rst_row_end", row_end, 0);
    check("mid_rst_last", last, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_ovf", ovf, 0);
    exp_q.delete();
    fill(1, 0, 1'b0);
    drain(0, DEPTH, -1);
    do_clear();

    // Randomized frames: random data, gaps, ready, and occasional stray write.
    for (int f = 0; f < 6; f++) begin
      int inj;
      inj = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, DEPTH - 1));
      fill(0, 30, 1'b1);
      drain(2, DEPTH, inj);
      check("rand_ovf", ovf, inj >= 0);
      do_clear();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/conv_result_streamer.md
Name: conv_result_streamer

Overview:
- Read-side companion to the convolution block's result capture.
- Buffers one full OUT_SIZE x OUT_SIZE output map arriving from the ReLU stage, which is a valid-only write stream with no backpressure.
- Once the map is complete, drains it in raster order over a valid/ready stream toward the external memory writer, with row-end and frame-last markers.
- Then waits for i_clear before accepting the next map.

Parameters:
- OUT_SIZE, 4, output map side length; buffer depth is OUT_SIZE**2; must be >= 1.
- DATA_WIDTH, 16, sample width; instantiated with `DW.
- CNT_W, $clog2(OUT_SIZE**2)+1, pointer/counter width; localparam.

Ports:
- i_clk, in, 1, clock.
- i_rst, in, 1, reset.
- i_en, in, 1, write strobe from the ReLU stage; one sample per asserted cycle.
- i_data, in, DATA_WIDTH (signed), write sample.
- i_clear, in, 1, abort or re-arm; returns the block to FILL with empty buffer.
- i_ready, in, 1, downstream accepts o_data this cycle.
- o_valid, out, 1, o_data holds a valid sample.
- o_data, out, DATA_WIDTH (signed), read sample.
- o_row_end, out, 1, qualifies o_data as the last column of a row.
- o_last, out, 1, qualifies o_data as the final sample of the map.
- o_done, out, 1, level; map fully drained.
- o_overflow, out, 1, sticky; a write was dropped.

Behaviour:
- Reset: i_rst is synchronous, active-high; clock is i_clk. On reset, all outputs are 0, state=FILL, wr_ptr=rd_ptr=0. Buffer contents need not be cleared. Reset has priority over every other input, including mid-drain.
- State FILL:
  - i_en=1 writes i_data to mem[wr_ptr]; wr_ptr increments.
  - The write with wr_ptr==OUT_SIZE**2-1 moves the state to PREFETCH on the next cycle.
  - Gaps in i_en are allowed; pointers hold.
- State PREFETCH (1 cycle):
  - mem[0] is read into the o_data register; o_valid stays 0.
  - Next state is DRAIN.
  - Latency: last write at cycle T gives o_valid=1 with o_data=mem[0] at T+2.
- State DRAIN:
  - o_valid=1 continuously.
  - A handshake is o_valid & i_ready. On a handshake, rd_ptr increments and o_data loads mem[rd_ptr+1] on the next edge. The read address is the next pointer on a handshake, so there are no bubbles at i_ready=1.
  - With o_valid=1 and i_ready=0, o_data, o_row_end and o_last hold stable.
  - o_row_end = (rd_ptr % OUT_SIZE == OUT_SIZE-1).
  - o_last = (rd_ptr == OUT_SIZE**2-1).
  - A handshake with o_last=1 moves the state to DONE.
- State DONE: o_valid=0, o_done=1. Holds until i_clear.
- i_clear (any state, not in reset): next cycle state=FILL, pointers 0, o_valid=o_done=o_row_end=o_last=0, o_overflow=0.
- i_clear and i_en in the same cycle: the write is ignored and not counted as overflow.
- i_en outside FILL, or on the same cycle as the FILL->PREFETCH transition after the final write, is dropped. Dropped writes set o_overflow, which is sticky until i_clear or reset. Buffer contents are unaffected.
- OUT_SIZE=1: the single write is followed by o_valid with o_row_end=o_last=1.
- Sample values pass bit-exact; no arithmetic is performed on data.

Test Plan:
1. OUT_SIZE=4, write 1..16 on consecutive cycles, i_ready=1 -> o_valid rises 2 cycles after the last write; o_data=1..16 on consecutive cycles; o_row_end on 4,8,12,16; o_last only on 16; o_done=1 the cycle after.
2. Same fill, i_ready toggling 1,0,0,1 pattern -> sequence still 1..16 with no loss or duplicates; o_data, o_row_end, o_last stable on every stalled cycle.
3. Writes 1..16 with random i_en gaps -> buffer order preserved; drain identical to scenario 1.
4. After fill completes, one extra i_en during DRAIN with data 99 -> o_overflow=1 and stays high; 99 never appears; drain unchanged; i_clear drops o_overflow to 0.
5. i_clear after 7 writes, then write 101..116 -> drained sequence is 101..116 only; o_done=0 until the final handshake.
6. i_rst asserted mid-drain (after 5 handshakes) -> next cycle all outputs 0, state FILL; a fresh 16-write fill drains correctly from the first sample.
